// File: rtl/panel_pkg.sv
// Shared constants and types for the 64x64 split framebuffer and its LED panel scanner.
// The pixel writer uses the same geometry and pixel field offsets.
package panel_pkg;

  localparam int COLS       = 64;
  localparam int HALF_ROWS  = 32;
  localparam int BPP_PER_CH = 4;
  localparam int PIX_W      = 3 * BPP_PER_CH;

  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    ADDR,
    DATA,
    CLK_HI,
    BLANK,
    LATCH,
    DISPLAY
  } state_e;

endpackage

// File: rtl/bcm_timer.sv
// Down-counter timing the oe_n-low window of one bitplane.
// done pulses in the last cycle of a window of exactly 'value' cycles after load.
module bcm_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = value - 1'b1;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) armed_d = 1'b0;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign done = armed_q && (cnt_q == '0);

endmodule

// File: rtl/led_panel_scan.sv
// HUB75 panel scanner: reads both framebuffer halves column by column and
// drives the panel with 4-bit binary-code modulation, one row pair at a time.
module led_panel_scan #(
  parameter int COLS       = panel_pkg::COLS,
  parameter int HALF_ROWS  = panel_pkg::HALF_ROWS,
  parameter int BASE_DELAY = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] rd_addr,
  input  logic [11:0] b_rdata0,
  input  logic [11:0] b_rdata1,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        panel_clk,
  output logic        lat,
  output logic        oe_n,
  output logic [4:0]  row_addr,
  output logic        frame_start
);
  import panel_pkg::*;

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(HALF_ROWS);
  localparam int BW = $clog2(BPP_PER_CH);
  localparam int IW = $clog2(PIX_W);
  localparam int TW = $clog2(BASE_DELAY * 8) + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [BW-1:0]  bitpl_q, bitpl_d;
  logic [RW-1:0]  shift_row_q, shift_row_d;
  logic [RW-1:0]  row_addr_q, row_addr_d;
  logic [5:0]     rgb_q, rgb_d;
  logic           tmr_load, tmr_done;
  logic [TW-1:0]  tmr_val;

  logic [IW-1:0] r_idx, g_idx, b_idx;
  assign r_idx = IW'(R_LSB) + IW'(bitpl_q);
  assign g_idx = IW'(G_LSB) + IW'(bitpl_q);
  assign b_idx = IW'(B_LSB) + IW'(bitpl_q);

  assign tmr_val = TW'(BASE_DELAY) << bitpl_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    bitpl_d     = bitpl_q;
    shift_row_d = shift_row_q;
    row_addr_d  = row_addr_q;
    rgb_d       = rgb_q;
    tmr_load    = 1'b0;
    case (state_q)
      ADDR:   state_d = DATA;
      // Read data for the address presented in ADDR arrives this cycle.
      DATA: begin
        rgb_d   = {b_rdata0[r_idx], b_rdata0[g_idx], b_rdata0[b_idx],
                   b_rdata1[r_idx], b_rdata1[g_idx], b_rdata1[b_idx]};
        state_d = CLK_HI;
      end
      CLK_HI: begin
        if (col_q == CW'(COLS - 1)) begin
          col_d   = '0;
          state_d = BLANK;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = ADDR;
        end
      end
      BLANK:  state_d = LATCH;
      LATCH: begin
        row_addr_d = shift_row_q;
        tmr_load   = 1'b1;
        state_d    = DISPLAY;
      end
      DISPLAY: begin
        if (tmr_done) begin
          if (bitpl_q == BW'(BPP_PER_CH - 1)) begin
            bitpl_d     = '0;
            shift_row_d = (shift_row_q == RW'(HALF_ROWS - 1)) ? '0 : shift_row_q + 1'b1;
          end else begin
            bitpl_d = bitpl_q + 1'b1;
          end
          state_d = ADDR;
        end
      end
      default: state_d = ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ADDR;
      col_q       <= '0;
      bitpl_q     <= '0;
      shift_row_q <= '0;
      row_addr_q  <= '0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      bitpl_q     <= bitpl_d;
      shift_row_q <= shift_row_d;
      row_addr_q  <= row_addr_d;
      rgb_q       <= rgb_d;
    end
  end

  bcm_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  // COLS is a power of two, so row*COLS + col is a plain concatenation.
  assign rd_addr   = 12'({shift_row_q, col_q});
  assign row_addr  = 5'(row_addr_q);
  assign {r0, g0, b0, r1, g1, b1} = rgb_q;
  assign panel_clk = (state_q == CLK_HI);
  assign lat       = (state_q == LATCH);
  assign oe_n      = (state_q != DISPLAY);
  // Gated by reset so the pulse stays low while reset holds the scan at its start.
  assign frame_start = !reset && (state_q == ADDR) && (shift_row_q == '0)
                       && (bitpl_q == '0) && (col_q == '0);

endmodule

// File: tb/tb_led_panel_scan.sv
// Bench for led_panel_scan: arithmetic scan-timeline model, hand-derived pixel table,
// and reset-in-display sequence.
module tb_led_panel_scan;
  localparam int COLS  = 64;
  localparam int HROWS = 32;
  localparam int BASE  = 64;
  localparam int SHIFT = 3 * COLS + 2;
  localparam int ROWP  = 4 * SHIFT + BASE * 15;
  localparam int FRAME = HROWS * ROWP;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rd_addr, b_rdata0, b_rdata1;
  logic        r0, g0, b0, r1, g1, b1, panel_clk, lat, oe_n, frame_start;
  logic [4:0]  row_addr;

  logic [11:0] mem0 [2048];
  logic [11:0] mem1 [2048];
  int checks = 0;
  int errors = 0;
  int hits   = 0;

  typedef struct {
    int          row;
    int          col;
    int          bp;
    logic [11:0] p0;
    logic [11:0] p1;
    logic [5:0]  exp_rgb;
  } vec_t;
  vec_t tbl [12];

  led_panel_scan #(.COLS(COLS), .HALF_ROWS(HROWS), .BASE_DELAY(BASE)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .b_rdata0(b_rdata0), .b_rdata1(b_rdata1),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .panel_clk(panel_clk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    b_rdata0 <= mem0[rd_addr[10:0]];
    b_rdata1 <= mem1[rd_addr[10:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Position in the scan timeline from cycles elapsed since the first ADDR cycle.
  function automatic void decode(input int t, output int r, output int bp, output int o);
    int ro;
    r  = (t % FRAME) / ROWP;
    ro = (t % FRAME) % ROWP;
    bp = 0;
    while (ro >= SHIFT + (BASE << bp)) begin
      ro -= SHIFT + (BASE << bp);
      bp++;
    end
    o = ro;
  endfunction

  task automatic run(input int n);
    int r, bp, o, c;
    int nplanes = 0, low = 0, rises = 0, last_fs = -1;
    logic prev_oe = 1'b1, prev_pclk = 1'b0;
    logic [20:0] expv, gotv;
    logic [11:0] p0, p1;
    logic [5:0]  exp_rgb;
    for (int t = 0; t < n && errors < 40; t++) begin
      decode(t, r, bp, o);
      c = (o < 3 * COLS) ? o / 3 : 0;
      expv = {12'(r * COLS + c),
              1'(o < 3 * COLS && o % 3 == 2),
              1'(o == SHIFT - 1),
              1'(o < SHIFT),
              5'((o >= SHIFT || bp > 0) ? r : ((t < FRAME && r == 0) ? 0 : (r + HROWS - 1) % HROWS)),
              1'(t % FRAME == 0)};
      gotv = {rd_addr, panel_clk, lat, oe_n, row_addr, frame_start};
      checks++;
      if (gotv !== expv) begin
        errors++;
        $display("FAIL scan t=%0d row=%0d bp=%0d off=%0d: got %h expected %h", t, r, bp, o, gotv, expv);
      end
      if (expv[8]) begin
        p0 = mem0[r * COLS + c];
        p1 = mem1[r * COLS + c];
        exp_rgb = {p0[8 + bp], p0[4 + bp], p0[bp], p1[8 + bp], p1[4 + bp], p1[bp]};
        chk("rgb model", {r0, g0, b0, r1, g1, b1}, exp_rgb);
        foreach (tbl[i]) begin
          if (tbl[i].row == r && tbl[i].col == c && tbl[i].bp == bp) begin
            hits++;
            chk("rgb table", {r0, g0, b0, r1, g1, b1}, tbl[i].exp_rgb);
          end
        end
      end
      if (prev_oe === 1'b0 && oe_n === 1'b1) begin
        chk("oe_n low width", low, BASE << (nplanes % 4));
        nplanes++;
        low = 0;
      end
      if (oe_n === 1'b0) low++;
      if (panel_clk === 1'b1 && prev_pclk === 1'b0) rises++;
      if (lat === 1'b1) begin
        chk("shift clocks before lat", rises, COLS);
        chk("lat while oe_n low", oe_n, 1);
        rises = 0;
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) chk("frame period", t - last_fs, FRAME);
        last_fs = t;
      end
      prev_oe   = oe_n;
      prev_pclk = panel_clk;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    foreach (mem0[i]) begin
      mem0[i] = 12'($urandom);
      mem1[i] = 12'($urandom);
    end
    tbl = '{
      '{0, 5, 0, 12'hF00, 12'h00F, 6'b100001}, '{0, 5, 1, 12'hF00, 12'h00F, 6'b100001},
      '{0, 5, 2, 12'hF00, 12'h00F, 6'b100001}, '{0, 5, 3, 12'hF00, 12'h00F, 6'b100001},
      '{1, 0, 0, 12'h5A3, 12'h000, 6'b101000}, '{1, 0, 1, 12'h5A3, 12'h000, 6'b011000},
      '{1, 0, 2, 12'h5A3, 12'h000, 6'b100000}, '{1, 0, 3, 12'h5A3, 12'h000, 6'b010000},
      '{31, 63, 0, 12'hFFF, 12'h8C1, 6'b111001}, '{31, 63, 1, 12'hFFF, 12'h8C1, 6'b111000},
      '{31, 63, 2, 12'hFFF, 12'h8C1, 6'b111010}, '{31, 63, 3, 12'hFFF, 12'h8C1, 6'b111110}
    };
    foreach (tbl[i]) begin
      mem0[tbl[i].row * COLS + tbl[i].col] = tbl[i].p0;
      mem1[tbl[i].row * COLS + tbl[i].col] = tbl[i].p1;
    end

    // Reset held three cycles: oe_n high, everything else low.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset outputs",
          {rd_addr, panel_clk, lat, oe_n, row_addr, frame_start, r0, g0, b0, r1, g1, b1},
          32'h0000_1000);
    end

    // One full frame plus the start of the next: timeline, widths, wrap, period.
    reset = 1'b0;
    #1;
    hits = 0;
    run(FRAME + 5);
    chk("table entries visited", hits, 12);

    // Restart, then hit reset in the middle of row 7, bitplane 2 display.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    run(7 * ROWP + (SHIFT + BASE) + (SHIFT + 2 * BASE) + SHIFT + 10);
    chk("in display before reset", oe_n, 0);
    reset = 1'b1;
    step();
    chk("oe_n after mid reset", oe_n, 1);
    chk("row_addr after mid reset", row_addr, 0);
    chk("rd_addr after mid reset", rd_addr, 0);
    chk("lat after mid reset", lat, 0);
    reset = 1'b0;
    #1;
    run(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
